// File: rtl/nibble_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : packer_pkg
// Brief    : Default sizing constants and lane-counter width helper.
// Revision : 1.0
// ============================================================================
package packer_pkg;

    localparam int IN_W_DEF  = 4;
    localparam int LANES_DEF = 4;

    // Width of a lane index; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_packer_lane_counter.sv
`default_nettype none
// ============================================================================
// Module   : lane_counter
// Brief    : Lane index counter, wraps at LANES-1, clear loads zero.
// Revision : 1.0
// ============================================================================
module lane_counter
    import packer_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int CNT_W = cnt_width(LANES_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(LANES - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            if (count == c_last) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
// Module   : nibble_packer
// Brief    : Packs LANES input lanes of IN_W bits into one registered word.
// Revision : 1.0
// ============================================================================
module nibble_packer
    import packer_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int LANES = LANES_DEF,
    localparam int OUT_W = IN_W * LANES,
    localparam int CNT_W = cnt_width(LANES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] lane
);

    localparam logic [CNT_W-1:0] c_last_lane = CNT_W'(LANES - 1);
    localparam int               c_asm_w     = IN_W * (LANES - 1);

    logic               w_last;
    logic               w_in_xfer;
    logic               w_complete;
    logic               w_out_xfer;
    // The top lane never needs storage: it goes straight into out_data.
    logic [c_asm_w-1:0] r_asm;

    assign w_last     = (lane == c_last_lane);
    assign in_ready   = !clear && !(w_last && out_valid && !out_ready);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_complete = w_in_xfer && w_last;
    assign w_out_xfer = out_valid && out_ready;

    lane_counter #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_lane_counter (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (w_in_xfer),
        .count (lane)
    );

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_asm <= '0;
        end else if (w_in_xfer) begin
            for (int k = 0; k < LANES - 1; k++) begin
                if (lane == CNT_W'(k)) begin
                    r_asm[k*IN_W +: IN_W] <= in_data;
                end
            end
        end
    end

    // A completing lane reloads the output even while the old word is being taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (w_complete) begin
            out_data  <= {in_data, r_asm};
            out_valid <= 1'b1;
        end else if (w_out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_packer
// Brief    : Scoreboard bench for nibble_packer with IN_W=4, LANES=4.
// Revision : 1.0
// ============================================================================
module tb_nibble_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  in_data = 4'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  lane;

    nibble_packer #(
        .IN_W  (4),
        .LANES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane      (lane)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int words_out = 0;
    int last_acc_cyc = 0;

    int          m_lane  = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_part  = '0;
    logic [15:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: evaluated mid-cycle, predicts the effect of the next posedge.
    always @(negedge clk) begin
        logic        exp_ready;
        logic [15:0] exp_w;
        cyc++;
        exp_ready = !clear && !(m_lane == 3 && m_valid && !out_ready);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("lane", 32'(lane), 32'(m_lane));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (reset) begin
            m_lane  = 0;
            m_part  = '0;
            m_valid = 1'b0;
            sb_q.delete();
        end else begin
            if (m_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_w = sb_q.pop_front();
                    check("out_word", 32'(out_data), 32'(exp_w));
                end
                words_out++;
                m_valid = 1'b0;
            end
            if (clear) begin
                m_lane = 0;
                m_part = '0;
            end else if (in_valid && exp_ready) begin
                last_acc_cyc = cyc;
                m_part[m_lane*4 +: 4] = in_data;
                if (m_lane == 3) begin
                    sb_q.push_back(m_part);
                    m_valid = 1'b1;
                    m_lane  = 0;
                end else begin
                    m_lane++;
                end
            end
        end
    end

    task automatic send(input logic [3:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int f_cyc;
        int w0;
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f_cyc;
        int w0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;

        // Basic word
        for (int i = 1; i <= 4; i++) send(4'(i));
        in_valid = 1'b0;
        @(negedge clk);
        check("word_4321", 32'(out_data), 32'h4321);
        @(posedge clk); #1;
        idle(2);

        // Backpressure: the completing lane stalls until out_ready rises
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(4'(i));
        in_data = 4'h8;
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'h0);
        check("bp_lane", 32'(lane), 32'h3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_no_bubble", 32'(out_valid), 32'h1);
        check("bp_word_8765", 32'(out_data), 32'h8765);
        @(posedge clk); #1;
        idle(2);

        // Clear mid-word with a concurrent valid input
        send(4'h1);
        send(4'h2);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 4'hF;
        @(posedge clk); #1;
        clear = 1'b0;
        send(4'hA); send(4'hB); send(4'hC); send(4'hD);
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_word_DCBA", 32'(out_data), 32'hDCBA);
        @(posedge clk); #1;
        idle(2);

        // Reset mid-word
        send(4'h5); send(4'h6); send(4'h7);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_data", 32'(out_data), 32'h0);
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_lane", 32'(lane), 32'h0);
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send(4'(i));
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_4321", 32'(out_data), 32'h4321);
        @(posedge clk); #1;
        idle(2);

        // Continuous 12-lane stream: one lane per cycle, three words
        w0 = words_out;
        send(4'($urandom));
        f_cyc = last_acc_cyc;
        for (int i = 1; i < 12; i++) send(4'($urandom));
        check("stream_cycles", 32'(last_acc_cyc - f_cyc), 32'd11);
        idle(3);
        check("stream_words", 32'(words_out - w0), 32'd3);

        // Random traffic with backpressure and occasional clears
        repeat (300) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        idle(4);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have parameter IN_W, default 4, meaning the width of one input lane in bits.
REQ-002 SHALL have parameter LANES, default 4, meaning the number of input lanes packed into one output word (LANES >= 2).
REQ-003 SHALL derive OUT_W = IN_W*LANES and CNT_W = max(1, clog2(LANES)) internally.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 clear  input  1  synchronous discard of the partially assembled word.
REQ-007 in_data  input  IN_W  input lane value.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  the block accepts in_data this cycle (combinational).
REQ-010 out_data  output  OUT_W  assembled word (registered).
REQ-011 out_valid  output  1  out_data holds a complete word (registered).
REQ-012 out_ready  input  1  the consumer takes out_data this cycle.
REQ-013 lane  output  CNT_W  index of the lane the next accepted input fills.

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both high at posedge clk; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-015 The first accepted lane of a word SHALL land in out_data[IN_W-1:0], and lane k SHALL land in bits [(k+1)*IN_W-1 : k*IN_W].
REQ-016 Each input transfer SHALL write in_data into the assembly register at lane index "lane" and increment lane.
REQ-017 lane SHALL wrap from LANES-1 to 0 on the transfer that completes a word.
REQ-018 On the completing transfer (lane == LANES-1), out_data SHALL load the assembly register lanes 0..LANES-2 concatenated with in_data as the top lane, and out_valid SHALL be 1 in the next cycle (latency 1 cycle from final lane to out_valid).
REQ-019 An output transfer without a simultaneous completing transfer SHALL clear out_valid; out_data SHALL keep its value.
REQ-020 A simultaneous output transfer and completing transfer SHALL load the new word with out_valid staying 1, with no bubble cycle.
REQ-021 in_ready SHALL be 0 when clear is 1, or when lane == LANES-1 and out_valid is 1 and out_ready is 0; otherwise in_ready SHALL be 1.
REQ-022 Non-completing lanes SHALL be accepted regardless of out_valid, so the next word assembles while the output is held.
REQ-023 Sustained throughput SHALL be one lane per cycle with out_ready high, giving one word every LANES cycles.
REQ-024 clear SHALL set lane to 0 and zero the assembly register, shall take priority over input acceptance, and shall not affect out_data, out_valid, or a concurrent output transfer.
REQ-025 While in_valid is low, lane and the assembly register SHALL hold their values.

Reset
REQ-026 reset SHALL set lane = 0, the assembly register = 0, out_data = 0, and out_valid = 0 at the next posedge clk, overriding clear and all transfers.
REQ-027 A reset in the middle of a word SHALL discard that partial word entirely, and the next accepted lane SHALL be lane 0.
REQ-028 in_ready SHALL follow REQ-021 while reset is asserted, but any input transfer during reset SHALL be ignored.

Structure
REQ-029 Package packer_pkg SHALL hold the default constants IN_W_DEF = 4 and LANES_DEF = 4 and the counter-width function used to compute CNT_W.
REQ-030 The lane index SHALL be one sub-module, lane_counter (synchronous reset, parallel load to 0 for clear, enable on input transfer, wrap at LANES-1); the assembly and output registers SHALL be written inline.

Verification (IN_W=4, LANES=4)
REQ-031 Lanes 1,2,3,4 on consecutive cycles with out_ready=1 -> out_valid=1 with out_data=16'h4321 in the cycle after the 4th lane; lane reads 0,1,2,3,0.
REQ-032 out_ready=0 and lanes 1..8 streamed -> in_ready drops at lane 8 with lane=3; raising out_ready -> 16'h4321 then 16'h8765, with no lane lost or duplicated.
REQ-033 Lanes 1,2, then clear=1 with in_valid=1 and in_data=F, then lanes A,B,C,D -> F not accepted; out_data=16'hDCBA.
REQ-034 Lanes 5,6,7, then reset, then lanes 1,2,3,4 -> out_valid=0 after reset with out_data=0; the next word is 16'h4321.
REQ-035 out_valid=1 and out_ready=1 in the same cycle the 4th lane of the next word is accepted -> in_ready=1 and out_valid stays 1 with the new word the next cycle; continuous 12-lane stream yields 3 words with no stall.
